// File: rtl/mem_arbiter_pkg.sv
// Shared constants and types for the memory-side line responder.
// Holds the line geometry, FSM state and requester encodings, and the round-robin pick rule.
package mem_arbiter_pkg;

    localparam int LINE_WIDTH   = 256;
    localparam int WORD_WIDTH   = 16;
    localparam int ADDR_WIDTH   = 16;
    localparam int OFFSET_WIDTH = 4;
    localparam int CNT_WIDTH    = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic {
        REQ_IC = 1'b0,
        REQ_DC = 1'b1
    } req_e;

    // On a tie the requester that was not granted last wins.
    function automatic req_e pick_grant(input logic ic_pet, input logic dc_pet, input req_e last);
        if (ic_pet && dc_pet) begin
            return (last == REQ_DC) ? REQ_IC : REQ_DC;
        end else if (dc_pet) begin
            return REQ_DC;
        end
        return REQ_IC;
    endfunction

endpackage

// File: rtl/mem_line_array.sv
// Single-port line store with registered read; a write also forwards the written line
// to the read register so the response reflects the committed data.
module mem_line_array #(
    parameter int lines = 256,
    parameter int width = 256
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     en,
    input  logic                     we,
    input  logic [$clog2(lines)-1:0] addr,
    input  logic [width-1:0]         wdata,
    output logic [width-1:0]         rdata
);

    logic [width-1:0] mem [lines];
    logic [width-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    // Contents survive reset; only the output register is cleared.
    always_ff @(posedge clk) begin
        if (srst) begin
            rdata_q <= '0;
        end else if (en) begin
            rdata_q <= we ? wdata : mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between instruction and data caches in front of a fixed-latency
// line store; returns one line per transaction with a single-cycle ready pulse.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int cache_line_width = LINE_WIDTH,
    parameter int addr_width       = ADDR_WIDTH,
    parameter int mem_lines        = 256,
    parameter int mem_latency      = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ic_petition,
    input  logic [addr_width-1:0]       ic_addr,
    output logic                        ic_ready,
    input  logic                        dc_petition,
    input  logic [addr_width-1:0]       dc_addr,
    input  logic                        dc_write,
    input  logic [cache_line_width-1:0] dc_wdata,
    output logic                        dc_ready,
    output logic [cache_line_width-1:0] resp_data
);

    localparam int IDX_W = $clog2(mem_lines);
    localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(mem_latency - 1);

    state_e                      state_q, state_d;
    logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
    req_e                        last_grant_q, last_grant_d;
    req_e                        owner_q, owner_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic                        write_q, write_d;
    logic [cache_line_width-1:0] wdata_q, wdata_d;
    logic                        ic_ready_q, ic_ready_d;
    logic                        dc_ready_q, dc_ready_d;
    logic                        access;
    logic                        mem_en;
    req_e                        grant;
    logic                        addr_unused;

    // Bits outside the line index select nothing: aliasing is intended.
    assign addr_unused = ^{ic_addr, dc_addr};

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        idx_d        = idx_q;
        write_d      = write_q;
        wdata_d      = wdata_q;
        ic_ready_d   = 1'b0;
        dc_ready_d   = 1'b0;
        access       = 1'b0;
        grant        = pick_grant(ic_petition, dc_petition, last_grant_q);

        case (state_q)
            ST_IDLE: begin
                if (ic_petition || dc_petition) begin
                    owner_d      = grant;
                    last_grant_d = grant;
                    cnt_d        = CNT_LOAD;
                    state_d      = ST_WAIT;
                    if (grant == REQ_DC) begin
                        idx_d   = dc_addr[IDX_W+OFFSET_WIDTH-1:OFFSET_WIDTH];
                        write_d = dc_write;
                        wdata_d = dc_wdata;
                    end else begin
                        idx_d   = ic_addr[IDX_W+OFFSET_WIDTH-1:OFFSET_WIDTH];
                        write_d = 1'b0;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end else begin
                    access     = 1'b1;
                    state_d    = ST_RESP;
                    ic_ready_d = (owner_q == REQ_IC);
                    dc_ready_d = (owner_q == REQ_DC);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A reset landing on the access edge must not commit the write.
    assign mem_en = access && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            last_grant_q <= REQ_DC;
            ic_ready_q   <= 1'b0;
            dc_ready_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            ic_ready_q   <= ic_ready_d;
            dc_ready_q   <= dc_ready_d;
        end
    end

    always_ff @(posedge clk) begin
        owner_q <= owner_d;
        idx_q   <= idx_d;
        write_q <= write_d;
        wdata_q <= wdata_d;
    end

    mem_line_array #(
        .lines (mem_lines),
        .width (cache_line_width)
    ) u_array (
        .clk   (clk),
        .srst  (reset),
        .en    (mem_en),
        .we    (write_q),
        .addr  (idx_q),
        .wdata (wdata_q),
        .rdata (resp_data)
    );

    assign ic_ready = ic_ready_q;
    assign dc_ready = dc_ready_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then random traffic
// checked every cycle against a transaction-level model of the responder.
module tb_mem_arbiter;

    localparam int L  = 4;
    localparam int L2 = 1;

    logic         clk = 1'b0;
    logic         reset;
    logic         ic_petition, dc_petition, dc_write;
    logic [15:0]  ic_addr, dc_addr;
    logic [255:0] dc_wdata, resp_data;
    logic         ic_ready, dc_ready;
    logic         ic2_petition, dc2_petition, dc2_write;
    logic [15:0]  ic2_addr, dc2_addr;
    logic [255:0] dc2_wdata, resp2_data;
    logic         ic2_ready, dc2_ready;

    always #5 clk = ~clk;

    mem_arbiter #(.mem_latency(L)) dut (
        .clk(clk), .reset(reset),
        .ic_petition(ic_petition), .ic_addr(ic_addr), .ic_ready(ic_ready),
        .dc_petition(dc_petition), .dc_addr(dc_addr), .dc_write(dc_write),
        .dc_wdata(dc_wdata), .dc_ready(dc_ready), .resp_data(resp_data)
    );

    mem_arbiter #(.mem_latency(L2)) dut2 (
        .clk(clk), .reset(reset),
        .ic_petition(ic2_petition), .ic_addr(ic2_addr), .ic_ready(ic2_ready),
        .dc_petition(dc2_petition), .dc_addr(dc2_addr), .dc_write(dc2_write),
        .dc_wdata(dc2_wdata), .dc_ready(dc2_ready), .resp_data(resp2_data)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic check_line(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [255:0] line_k(input logic [15:0] base);
        logic [255:0] l;
        for (int k = 0; k < 16; k++) l[k*16 +: 16] = base + 16'(k);
        return l;
    endfunction

    // ---------------- transaction-level model of dut ----------------
    logic [255:0] mdl_mem [256];
    bit           mdl_known [256];
    bit           m_valid = 0, m_busy = 0, m_who = 0, m_wr = 0, m_last = 1;
    int           m_tready = 0, m_idx = 0;
    logic [255:0] m_wdata = '0;
    bit           e_ic = 0, e_dc = 0, e_known = 0;
    logic [255:0] e_resp = '0;

    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            check_bit("ic_ready", ic_ready, e_ic);
            check_bit("dc_ready", dc_ready, e_dc);
            check_bit("ready_exclusive", ic_ready & dc_ready, 1'b0);
            if (e_known) check_line("resp_data", resp_data, e_resp);
        end
        // inputs now visible are the ones sampled at the coming edge
        e_ic = 0;
        e_dc = 0;
        if (reset) begin
            m_busy  = 0;
            m_last  = 1;
            e_resp  = '0;
            e_known = 1;
            m_valid = 1;
        end else if (m_valid) begin
            if (m_busy && cyc == m_tready) begin
                m_busy = 0;
            end else if (!m_busy && (ic_petition || dc_petition)) begin
                m_who    = (ic_petition && dc_petition) ? !m_last : dc_petition;
                m_last   = m_who;
                m_busy   = 1;
                m_tready = cyc + L + 1;
                if (m_who) begin
                    m_idx   = (int'(dc_addr) >> 4) % 256;
                    m_wr    = dc_write;
                    m_wdata = dc_wdata;
                end else begin
                    m_idx = (int'(ic_addr) >> 4) % 256;
                    m_wr  = 0;
                end
            end
            if (m_busy && cyc + 1 == m_tready) begin
                if (m_wr) begin
                    mdl_mem[m_idx]   = m_wdata;
                    mdl_known[m_idx] = 1;
                    e_resp  = m_wdata;
                    e_known = 1;
                end else begin
                    e_resp  = mdl_mem[m_idx];
                    e_known = mdl_known[m_idx];
                end
                e_ic = !m_who;
                e_dc = m_who;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic ready_of(input int sel);
        case (sel)
            0:       return ic_ready;
            1:       return dc_ready;
            2:       return ic2_ready;
            default: return dc2_ready;
        endcase
    endfunction

    task automatic wait_ready(input int sel, input string name, output int at);
        at = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ready_of(sel) === 1'b1) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: got no ready expected ready within 40 cycles", name);
        end
    endtask

    task automatic do_txn(input bit is_dc, input bit wr, input logic [15:0] addr,
                          input logic [255:0] wd, input string name);
        int t0, at;
        tick();
        if (is_dc) begin
            dc_petition = 1; dc_write = wr; dc_addr = addr; dc_wdata = wd;
        end else begin
            ic_petition = 1; ic_addr = addr;
        end
        t0 = cyc;
        wait_ready(is_dc ? 1 : 0, name, at);
        if (at >= 0) begin
            check_int({name, "_latency"}, at - t0, L + 1);
            check_bit({name, "_other_quiet"}, is_dc ? ic_ready : dc_ready, 1'b0);
        end
        tick();
        if (is_dc) dc_petition = 0; else ic_petition = 0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int t0, at;
        reset = 1;
        ic_petition = 0; ic_addr = '0; dc_petition = 0; dc_addr = '0; dc_write = 0; dc_wdata = '0;
        ic2_petition = 0; ic2_addr = '0; dc2_petition = 0; dc2_addr = '0; dc2_write = 0; dc2_wdata = '0;
        repeat (3) tick();
        check_bit("reset_ic_ready", ic_ready, 1'b0);
        check_bit("reset_dc_ready", dc_ready, 1'b0);
        check_line("reset_resp", resp_data, '0);
        reset = 0;

        // write then read the same line
        do_txn(1, 1, 16'h0120, line_k(16'hA000), "dc_write_0120");
        do_txn(0, 0, 16'h0125, '0, "ic_read_0125");
        check_int("ic_read_word5", int'(resp_data[5*16 +: 16]), 32'hA005);
        tick();
        check_line("resp_held", resp_data, line_k(16'hA000));

        // simultaneous petitions straight out of reset
        reset = 1;
        tick();
        reset = 0;
        ic_petition = 1; ic_addr = 16'h0400;
        dc_petition = 1; dc_write = 1; dc_addr = 16'h0500; dc_wdata = line_k(16'hB000);
        t0 = cyc;
        wait_ready(0, "tie1_ic", at);
        check_int("tie1_ic_latency", at - t0, 5);
        tick();
        ic_petition = 0;
        wait_ready(1, "tie1_dc", at);
        check_int("tie1_dc_latency", at - t0, 11);
        tick();
        ic_petition = 1; ic_addr = 16'h0500;
        dc_petition = 1; dc_write = 0; dc_addr = 16'h0400;
        t0 = cyc;
        wait_ready(0, "tie2_ic", at);
        check_int("tie2_ic_latency", at - t0, 5);
        check_line("tie2_ic_data", resp_data, line_k(16'hB000));
        tick();
        ic_petition = 0;
        wait_ready(1, "tie2_dc", at);
        tick();
        dc_petition = 0;

        // petition withdrawn mid-write still commits
        tick();
        dc_petition = 1; dc_write = 1; dc_addr = 16'h0200; dc_wdata = line_k(16'hC000);
        t0 = cyc;
        tick();
        tick();
        dc_petition = 0; dc_addr = 16'h0700; dc_wdata = line_k(16'h1111);
        wait_ready(1, "drop_dc", at);
        check_int("drop_dc_latency", at - t0, 5);
        do_txn(0, 0, 16'h0200, '0, "ic_read_0200");
        check_line("drop_commit_data", resp_data, line_k(16'hC000));

        // reset during WAIT aborts the write
        do_txn(1, 1, 16'h0300, line_k(16'hD000), "dc_write_0300");
        tick();
        dc_petition = 1; dc_write = 1; dc_addr = 16'h0300; dc_wdata = line_k(16'hE000);
        tick();
        tick();
        reset = 1; dc_petition = 0;
        tick();
        reset = 0;
        check_bit("abort_ic_ready", ic_ready, 1'b0);
        check_bit("abort_dc_ready", dc_ready, 1'b0);
        check_line("abort_resp", resp_data, '0);
        repeat (8) tick();
        do_txn(0, 0, 16'h0300, '0, "ic_read_0300");
        check_line("abort_old_data", resp_data, line_k(16'hD000));

        // latency-1 instance: timing and address aliasing
        tick();
        dc2_petition = 1; dc2_write = 1; dc2_addr = 16'h0120; dc2_wdata = line_k(16'h5000);
        t0 = cyc;
        wait_ready(3, "l1_dc", at);
        check_int("l1_dc_latency", at - t0, 2);
        tick();
        dc2_petition = 0;
        ic2_petition = 1; ic2_addr = 16'h1120;
        t0 = cyc;
        wait_ready(2, "l1_ic", at);
        check_int("l1_ic_latency", at - t0, 2);
        check_line("l1_alias_data", resp2_data, line_k(16'h5000));
        tick();
        ic2_petition = 0;

        // random traffic on a few lines with aliasing high bits
        for (int i = 0; i < 3000; i++) begin
            tick();
            reset       = ($urandom_range(299) == 0);
            ic_petition = ($urandom_range(1) == 0);
            dc_petition = ($urandom_range(2) == 0);
            dc_write    = ($urandom_range(1) == 0);
            ic_addr     = 16'($urandom) & 16'hF07F;
            dc_addr     = 16'($urandom) & 16'hF07F;
            for (int w = 0; w < 8; w++) dc_wdata[w*32 +: 32] = $urandom;
        end
        tick();
        reset = 0; ic_petition = 0; dc_petition = 0;
        repeat (10) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
